instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Parametrised instruction fetch stage for the KGP-RISC core. It owns the program counter and issues word reads to a synchronous single-port instruction ROM with fixed one-cycle read latency. Fetched words are buffered in a small prefetch queue and presented downstream with a valid/ready handshake. It supports stall by backpressure, fetch enable, and branch/jump redirect with flush of queued and in-flight words.

## Interface
- PC_W, 32, program counter width
- INSTR_W, 32, instruction word width
- ROM_AW, 12, ROM address width; `rom_addr` is `pc_q[ROM_AW-1:0]`
- Q_DEPTH, 4, prefetch queue depth, power of two, ≥2
- RESET_PC, 0, PC value loaded on reset
- PC_INC, 1, PC increment per fetched word (ROM is word-addressed)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- fetch_en  in  1  permits new ROM requests; does not gate output
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_W  new fetch target
- rom_en  out  1  ROM read request this cycle
- rom_addr  out  ROM_AW  ROM word address
- rom_data  in  INSTR_W  ROM read data, valid the cycle after `rom_en`
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  downstream accepts the head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  PC_W  PC of the head instruction

## Operation
- State: `pc_q`, `infl_q` (request issued last cycle), `infl_pc_q`, queue with `count`.
- Issue condition: `fetch_en & ~redirect_valid & (count + infl_q < Q_DEPTH)`.
  - When issuing: `rom_en=1`, `infl_q<=1`, `infl_pc_q<=pc_q`, `pc_q<=pc_q+PC_INC`, modulo 2^PC_W.
  - Otherwise: `rom_en=0`, `infl_q<=0`.
- Return: when `infl_q=1` and no redirect, `{rom_data, infl_pc_q}` is pushed into the queue.
- Pop: occurs when `out_valid & out_ready`. Push and pop in the same cycle leave `count` unchanged.
- The credit rule guarantees a push never hits a full queue. A pop on an empty queue is impossible because `out_valid=0`.
- Redirect in cycle t has priority over all other events:
  - queue is cleared (`count<=0`)
  - data returning in cycle t is discarded
  - `infl_q<=0` and `pc_q<=redirect_pc`
  - no issue in cycle t
  - a pop presented in cycle t is not a handshake; `out_valid` still reflects the pre-flush head, and downstream must ignore it.
- `fetch_en=0` stops issuing only. The queue continues to drain, and an in-flight word is still pushed.
- PC wrap: `0xFFFFFFFF + 1 -> 0`. `rom_addr` truncates the PC, so the ROM aliases.

## Timing
- Reset values:
  - `pc_q=RESET_PC`, `infl_q=0`, `count=0`
  - `rom_en=0`, `rom_addr=RESET_PC[ROM_AW-1:0]`
  - `out_valid=0`, `out_instr=0`, `out_pc=0`
- Reset asserted mid-operation aborts everything immediately. The first issue happens in the first cycle after deassertion when `fetch_en=1`.
- `rom_en`/`rom_addr` are combinational from registered state plus `fetch_en`/`redirect_valid`. `out_*` come from the queue registers, with no combinational path from `out_ready`.
- Latency: issue in cycle t, push at the end of t+1, `out_valid` in t+2.
- After a redirect in cycle t, the target is issued in t+1 and `out_valid` rises in t+3.
- Steady state with `out_ready=1`: one instruction per cycle.
- With `out_ready=0`: at most Q_DEPTH words are buffered, then `rom_en` stays 0.

## Structure
- Shared package `kgp_pkg`:
  - widths PC_W, INSTR_W, ROM_AW
  - RESET_PC
  - `fetch_entry_t` = `{pc, instr}`
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`. It has push, pop, flush, a count output, and wrap-around read/write pointers of width log2(Q_DEPTH). Flush wins over push.
- Top level holds the PC, in-flight tracking, and issue/redirect logic.
- The ROM lives outside this block; the bench models it.

## Test plan
- Reset, `fetch_en=1`, `out_ready=1`, ROM[i]=0x1000+i -> `out_valid` in cycle 2 after reset release; then (pc,instr) = (0,0x1000), (1,0x1001)… one per cycle.
- `out_ready=0` for 10 cycles -> exactly 4 words buffered; `rom_en` stays 0 after the 4th issue; on release, words PC 0..3 then 4 with no loss or duplicate.
- Redirect to 0x40 while 3 words are queued and 1 in flight -> queue empties; in-flight word dropped; `rom_addr=0x40` next cycle; `out_valid` 3 cycles after redirect with `out_pc=0x40`.
- `fetch_en` low for 5 cycles mid-stream -> in-flight word delivered, queue drains, no new issues; resume continues at the next sequential PC.
- Redirect to 0xFFFFFFFF -> output PCs 0xFFFFFFFF, 0x0, 0x1; `rom_addr` 0xFFF, 0x000, 0x001.
- Reset asserted with a full queue and `redirect_valid=1` -> all outputs take reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC fetch path: default widths, reset PC
// and the prefetch queue entry layout.
package kgp_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ROM_AW  = 12;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch entries with flush; flush beats push,
// and storage resets to zero so the head reads as zero out of reset.
module fetch_queue
    import kgp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [AW:0]  count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign pop_ok = pop & (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// KGP-RISC fetch stage: owns the PC, issues one-cycle-latency ROM reads under
// a queue credit rule, and handles redirect with flush of queued/in-flight words.
module instr_fetch_unit
    import kgp_pkg::fetch_entry_t;
#(
    parameter int unsigned     PC_W     = kgp_pkg::PC_W,
    parameter int unsigned     INSTR_W  = kgp_pkg::INSTR_W,
    parameter int unsigned     ROM_AW   = kgp_pkg::ROM_AW,
    parameter int unsigned     Q_DEPTH  = 4,
    parameter logic [PC_W-1:0] RESET_PC = kgp_pkg::RESET_PC,
    parameter int unsigned     PC_INC   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               rom_en,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    localparam int unsigned     CW      = $clog2(Q_DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_L = (CW+1)'(Q_DEPTH);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    logic [PC_W-1:0] pc_q;
    logic            infl_q;
    logic [PC_W-1:0] infl_pc_q;

    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Queue slots plus the word in flight must never exceed the queue depth,
    // so a returning word always has room.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, infl_q};
    assign issue       = ~reset & fetch_en & ~redirect_valid & (credit_used < DEPTH_L);

    assign rom_en   = issue;
    assign rom_addr = pc_q[ROM_AW-1:0];

    assign push             = infl_q & ~redirect_valid;
    assign pop              = out_valid & out_ready & ~redirect_valid;
    assign push_entry.pc    = infl_pc_q;
    assign push_entry.instr = rom_data;

    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q   <= redirect_pc;
            infl_q <= 1'b0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                infl_pc_q <= pc_q;
                pc_q      <= pc_q + PC_STEP;
            end
        end
    end

    fetch_queue #(
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected program-order stream per
// redirect/reset, monitor compares every handshake and every ROM request.
module tb_instr_fetch_unit;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ROM_AW  = 12;
    localparam int unsigned Q_DEPTH = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               fetch_en;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               rom_en;
    logic [ROM_AW-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data = '0;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    exp_t            exp_q[$];
    logic [PC_W-1:0] issue_pc;
    int              outstanding = 0;
    int              n_chk = 0;
    int              n_fail = 0;
    int              n_hs = 0;
    int              issues;

    always #5 clock = ~clock;

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .ROM_AW   (ROM_AW),
        .Q_DEPTH  (Q_DEPTH),
        .RESET_PC (32'h0),
        .PC_INC   (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    function automatic logic [INSTR_W-1:0] rom_word(input logic [ROM_AW-1:0] a);
        return 32'h1000 + {20'h0, a};
    endfunction

    // Synchronous ROM with one-cycle read latency.
    always @(posedge clock) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order restarts at pc after a reset or redirect.
    task automatic sb_restart(input logic [PC_W-1:0] pc);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            e.pc    = pc + PC_W'(i);
            e.instr = rom_word(e.pc[ROM_AW-1:0]);
            exp_q.push_back(e);
        end
        issue_pc = pc;
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic hs;
        if (reset) begin
            outstanding = 0;
        end else if (redirect_valid) begin
            chk("rom_en_during_redirect", rom_en, 0);
            outstanding = 0;
        end else begin
            hs = out_valid && out_ready;
            chk("rom_en_credit", rom_en, (fetch_en && outstanding < int'(Q_DEPTH)) ? 1 : 0);
            if (rom_en) begin
                chk("rom_addr_seq", rom_addr, issue_pc[ROM_AW-1:0]);
                issue_pc = issue_pc + 1;
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                    n_hs++;
                end
            end
            outstanding = outstanding + (rom_en ? 1 : 0) - (hs ? 1 : 0);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_out_pc"}, out_pc, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        sb_restart(32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        sb_restart(32'h0);

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("reset");

        // Streaming start-up latency
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("c0_rom_en", rom_en, 1);
        chk("c0_out_valid", out_valid, 0);
        @(negedge clock);
        chk("c1_out_valid", out_valid, 0);
        @(negedge clock);
        chk("c2_out_valid", out_valid, 1);
        chk("c2_out_pc", out_pc, 0);
        chk("c2_out_instr", out_instr, 32'h1000);
        repeat (8) @(posedge clock);

        // Backpressure fills exactly Q_DEPTH words
        #1 out_ready = 1'b0;
        pulse_reset();
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rom_en) issues++;
        end
        chk("bp_issue_count", issues, Q_DEPTH);
        chk("bp_rom_en_held", rom_en, 0);
        chk("bp_head_valid", out_valid, 1);
        chk("bp_head_pc", out_pc, 0);
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clock);

        // Redirect with 3 queued and 1 in flight
        #1 out_ready = 1'b0;
        pulse_reset();
        repeat (4) @(posedge clock);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        out_ready      = 1'b1;
        sb_restart(32'h40);
        @(negedge clock);
        chk("rd_preflush_valid", out_valid, 1);
        chk("rd_preflush_pc", out_pc, 0);
        @(posedge clock); #1;
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("rd_t1_rom_en", rom_en, 1);
        chk("rd_t1_rom_addr", rom_addr, 12'h040);
        chk("rd_t1_out_valid", out_valid, 0);
        @(negedge clock);
        chk("rd_t2_out_valid", out_valid, 0);
        @(negedge clock);
        chk("rd_t3_out_valid", out_valid, 1);
        chk("rd_t3_out_pc", out_pc, 32'h40);

        // fetch_en low mid-stream: drain only
        repeat (5) @(posedge clock);
        #1 fetch_en = 1'b0;
        issues = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (rom_en) issues++;
        end
        chk("fe_low_issues", issues, 0);
        chk("fe_low_drained", out_valid, 0);
        @(posedge clock); #1;
        fetch_en = 1'b1;
        repeat (6) @(posedge clock);

        // PC wrap and ROM aliasing
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        sb_restart(32'hFFFF_FFFF);
        @(posedge clock); #1;
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("wrap_addr0", rom_addr, 12'hFFF);
        @(negedge clock);
        chk("wrap_addr1", rom_addr, 12'h000);
        @(negedge clock);
        chk("wrap_addr2", rom_addr, 12'h001);
        chk("wrap_head_pc", out_pc, 32'hFFFF_FFFF);
        chk("wrap_head_instr", out_instr, 32'h1FFF);
        repeat (5) @(posedge clock);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            fetch_en  = ($urandom_range(9) < 8);
            out_ready = ($urandom_range(9) < 6);
            if ($urandom_range(19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFFF - 32'($urandom_range(3)));
                sb_restart(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clock); #1;
        redirect_valid = 1'b0;

        // Asynchronous reset over a full queue with redirect asserted
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        chk("full_before_reset", out_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h123;
        #2 reset = 1'b1;
        sb_restart(32'h0);
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clock); #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("restart_rom_en", rom_en, 1);
        chk("restart_rom_addr", rom_addr, 0);
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("handshakes_seen", (n_hs > 50) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
